// File: rtl/gen_sched_pkg.sv
// Shared types and defaults for the round-robin generator scheduler.
package gen_sched_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_N_REQ = 4;

  // IDLE: core free; LAUNCH: one-cycle start pulse; RUN: values routed to owner.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } sched_state_e;

endpackage

// File: rtl/gen_rr_pick.sv
// Rotate-priority picker: returns the first asserted request at or after ptr,
// wrapping past N_REQ-1 back to 0. Purely combinational.
module gen_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    int cand;
    // NOTE: every output gets a default before the loop so no path can infer a latch.
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    cand   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      // Modulo keeps the rotation correct when N_REQ is not a power of two.
      cand = (int'(ptr) + k) % N_REQ;
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        index        = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/gen_rr_scheduler.sv
// Shares one start/ready/valid/done generator core between N_REQ requesters.
// A round-robin pick launches the core with the winner's (base, limit, step),
// routes yielded values back under the winner's ready, then moves on.
module gen_rr_scheduler
  import gen_sched_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   _clock,
  input  logic                   _reset,
  // requester side
  input  logic [N_REQ-1:0]       req_start,
  input  logic [N_REQ*WIDTH-1:0] req_base,
  input  logic [N_REQ*WIDTH-1:0] req_limit,
  input  logic [N_REQ*WIDTH-1:0] req_step,
  input  logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_done,
  output logic [WIDTH-1:0]       req_0,
  // core side
  output logic                   core_start,
  output logic [WIDTH-1:0]       core_base,
  output logic [WIDTH-1:0]       core_limit,
  output logic [WIDTH-1:0]       core_step,
  output logic                   core_ready,
  input  logic                   core_valid,
  input  logic                   core_done,
  input  logic [WIDTH-1:0]       core_0
);

  localparam int IDX_W = $clog2(N_REQ);

  sched_state_e state_q, state_d;

  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [WIDTH-1:0] base_q, limit_q, step_q;

  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_req;
  logic [N_REQ-1:0] pick_hot;
  logic             pick_any;
  logic             owner_ready;
  logic             complete;
  logic             load;

  // ---------------------------------------------------------------------------
  // Arbitration inputs
  // ---------------------------------------------------------------------------
  // The owner's ready gates the core; completion needs the core to see it.
  assign owner_ready = req_ready[owner_q];
  assign complete    = (state_q == RUN) && core_done && owner_ready;

  // Slot after the current owner, wrapping N_REQ-1 -> 0.
  assign next_ptr = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  // In IDLE everybody competes from the stored pointer. At a completion edge
  // the owner is excluded and the search starts just past it, so a still-held
  // owner request waits until every other pending requester has been served.
  assign pick_req = (state_q == IDLE) ? req_start : (req_start & ~grant_q);
  assign pick_ptr = (state_q == IDLE) ? ptr_q : next_ptr;

  gen_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .onehot (pick_hot),
    .index  (pick_idx),
    .any    (pick_any)
  );

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // Next-state, next-owner and pointer update.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          load    = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        // Exactly one cycle; core outputs during this cycle are stale.
        state_d = RUN;
      end
      RUN: begin
        if (complete) begin
          ptr_d = next_ptr;
          if (pick_any) begin
            // Back-to-back handover, no IDLE bubble.
            load    = 1'b1;
            state_d = LAUNCH;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    if (load) begin
      owner_d = pick_idx;
      grant_d = pick_hot;
    end
  end

  // State, owner, grant and round-robin pointer registers.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      // NOTE: sequential state uses <= only, so every reader in this edge sees the old value.
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Argument capture: the winner's slice is sampled only at its grant edge.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      // NOTE: these are three plain registers, not a memory, so they are reset to keep core_* defined.
      base_q  <= '0;
      limit_q <= '0;
      step_q  <= '0;
    end else if (load) begin
      base_q  <= req_base [pick_idx*WIDTH +: WIDTH];
      limit_q <= req_limit[pick_idx*WIDTH +: WIDTH];
      step_q  <= req_step [pick_idx*WIDTH +: WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Output routing
  // ---------------------------------------------------------------------------
  assign grant      = grant_q;
  assign core_start = (state_q == LAUNCH);
  assign core_base  = base_q;
  assign core_limit = limit_q;
  assign core_step  = step_q;
  // Broadcast value; req_valid says who it belongs to.
  assign req_0      = core_0;

  // Ready/valid/done steering between the core and the current owner.
  always_comb begin
    core_ready = 1'b1;
    req_valid  = '0;
    req_done   = '0;
    if (state_q == RUN) begin
      core_ready = owner_ready;
      req_valid  = grant_q & {N_REQ{core_valid && owner_ready}};
      req_done   = grant_q & {N_REQ{complete}};
    end
  end

endmodule
